ecc_op_sequencer: RTL and testbench

- Sequences one ECC operation (encode, decode, or full channel) after the APB register block raises start.
- Sits between the APB register block (start, CTRL, CODEWORD_WIDTH) and the encoder/decoder datapath units.
- Latches the configuration, issues start pulses to the encoder and/or decoder, and waits on their done handshakes with a per-stage timeout.
- Reports busy, a one-cycle operation_done, the error count and a status code.

---
 rtl/ecc_op_sequencer_if.sv | 41 ++++
 rtl/ecc_op_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ecc_op_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_op_sequencer_if
//  Description : Handshake bundle between the ECC operation sequencer, the
//                APB register block and the encoder/decoder datapath units.
//  Revision    : 1.0  initial release
// ============================================================================
interface ecc_op_sequencer_if;
    // Request side (APB register block)
    logic       start;
    logic [1:0] ctrl_mode;
    logic [1:0] cw_width;
    // Datapath completion handshakes
    logic       enc_done;
    logic       dec_done;
    logic [1:0] dec_err;
    // Sequencer outputs
    logic       enc_start;
    logic       dec_start;
    logic       dec_src;
    logic [1:0] width_lat;
    logic       busy;
    logic       operation_done;
    logic [1:0] num_of_errors;
    logic [1:0] status;

    // Environment side: issues requests and done handshakes
    modport master (
        output start, ctrl_mode, cw_width, enc_done, dec_done, dec_err,
        input  enc_start, dec_start, dec_src, width_lat, busy,
               operation_done, num_of_errors, status
    );

    // Sequencer side
    modport slave (
        input  start, ctrl_mode, cw_width, enc_done, dec_done, dec_err,
        output enc_start, dec_start, dec_src, width_lat, busy,
               operation_done, num_of_errors, status
    );
endinterface
`default_nettype wire

// File: rtl/ecc_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_op_sequencer
//  Description : Runs one ECC operation (encode, decode or full channel):
//                latches the configuration, kicks the encoder and/or decoder,
//                waits for their done pulses with a per-stage timeout and
//                reports completion, error count and status.
//  Revision    : 1.0  initial release
// ============================================================================
module ecc_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input wire logic          clk,
    input wire logic          rst,
    ecc_op_sequencer_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ENC  = 2'd1;
    localparam logic [1:0] c_ST_DEC  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [1:0] c_MODE_ENC  = 2'b00;
    localparam logic [1:0] c_MODE_DEC  = 2'b01;
    localparam logic [1:0] c_MODE_FULL = 2'b10;
    localparam logic [1:0] c_ILLEGAL   = 2'b11;

    localparam logic [1:0] c_STAT_OK   = 2'b00;
    localparam logic [1:0] c_STAT_CFG  = 2'b01;
    localparam logic [1:0] c_STAT_TOUT = 2'b10;

    // Last counter value of a stage; a stage lasts at most TIMEOUT_CYCLES cycles
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state, w_nxt_state;
    logic [CNT_W-1:0] r_cnt,   w_nxt_cnt;
    logic [1:0]       r_mode,  w_nxt_mode;
    logic [1:0]       r_width, w_nxt_width;
    logic             r_src,   w_nxt_src;
    logic             r_enc_start, w_nxt_enc_start;
    logic             r_dec_start, w_nxt_dec_start;
    logic             r_op_done,   w_nxt_op_done;
    logic [1:0]       r_errs,   w_nxt_errs;
    logic [1:0]       r_status, w_nxt_status;
    logic             w_timeout;

    assign w_timeout = (r_cnt == c_CNT_MAX);

    // State and all outputs are registered; reset clears everything, dropping any pulse in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_mode      <= 2'b00;
            r_width     <= 2'b00;
            r_src       <= 1'b0;
            r_enc_start <= 1'b0;
            r_dec_start <= 1'b0;
            r_op_done   <= 1'b0;
            r_errs      <= 2'b00;
            r_status    <= 2'b00;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_mode      <= w_nxt_mode;
            r_width     <= w_nxt_width;
            r_src       <= w_nxt_src;
            r_enc_start <= w_nxt_enc_start;
            r_dec_start <= w_nxt_dec_start;
            r_op_done   <= w_nxt_op_done;
            r_errs      <= w_nxt_errs;
            r_status    <= w_nxt_status;
        end
    end

    // Next-state and next-output decode; results hold unless a transition updates them
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_cnt;
        w_nxt_mode      = r_mode;
        w_nxt_width     = r_width;
        w_nxt_src       = r_src;
        w_nxt_enc_start = 1'b0;
        w_nxt_dec_start = 1'b0;
        w_nxt_op_done   = 1'b0;
        w_nxt_errs      = r_errs;
        w_nxt_status    = r_status;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    w_nxt_mode  = bus.ctrl_mode;
                    w_nxt_width = bus.cw_width;
                    w_nxt_src   = (bus.ctrl_mode == c_MODE_FULL);
                    w_nxt_cnt   = '0;
                    if (bus.ctrl_mode == c_ILLEGAL || bus.cw_width == c_ILLEGAL) begin
                        w_nxt_state   = c_ST_DONE;
                        w_nxt_status  = c_STAT_CFG;
                        w_nxt_errs    = 2'b00;
                        w_nxt_op_done = 1'b1;
                    end else if (bus.ctrl_mode == c_MODE_DEC) begin
                        w_nxt_state     = c_ST_DEC;
                        w_nxt_dec_start = 1'b1;
                    end else begin
                        w_nxt_state     = c_ST_ENC;
                        w_nxt_enc_start = 1'b1;
                    end
                end
            end
            c_ST_ENC: begin
                // A done in the final stage cycle takes priority over the timeout
                if (bus.enc_done) begin
                    w_nxt_cnt = '0;
                    if (r_mode == c_MODE_FULL) begin
                        w_nxt_state     = c_ST_DEC;
                        w_nxt_dec_start = 1'b1;
                    end else begin
                        w_nxt_state   = c_ST_DONE;
                        w_nxt_status  = c_STAT_OK;
                        w_nxt_errs    = 2'b00;
                        w_nxt_op_done = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_nxt_state   = c_ST_DONE;
                    w_nxt_status  = c_STAT_TOUT;
                    w_nxt_errs    = 2'b00;
                    w_nxt_op_done = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_DEC: begin
                if (bus.dec_done) begin
                    w_nxt_state   = c_ST_DONE;
                    w_nxt_status  = c_STAT_OK;
                    w_nxt_errs    = bus.dec_err;
                    w_nxt_op_done = 1'b1;
                end else if (w_timeout) begin
                    w_nxt_state   = c_ST_DONE;
                    w_nxt_status  = c_STAT_TOUT;
                    w_nxt_errs    = 2'b00;
                    w_nxt_op_done = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_DONE: begin
                w_nxt_state = c_ST_IDLE;
            end
            default: begin
                w_nxt_state = c_ST_IDLE;
            end
        endcase
    end

    assign bus.enc_start      = r_enc_start;
    assign bus.dec_start      = r_dec_start;
    assign bus.dec_src        = r_src;
    assign bus.width_lat      = r_width;
    assign bus.busy           = (r_state != c_ST_IDLE);
    assign bus.operation_done = r_op_done;
    assign bus.num_of_errors  = r_errs;
    assign bus.status         = r_status;

endmodule
`default_nettype wire

// File: tb/tb_ecc_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecc_op_sequencer
//  Description : Self-checking bench for ecc_op_sequencer; directed and
//                randomized operations compared with an operation-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ecc_op_sequencer;

    localparam int c_T = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ecc_op_sequencer_if bus ();

    ecc_op_sequencer #(.TIMEOUT_CYCLES(c_T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operation-level model. Delays count cycles from the kick cycle (0 = done
    // in the kick cycle); a delay >= c_T means the done pulse is withheld.
    // Cycle numbers are relative to the start cycle E = 0.
    function automatic void model(input logic [1:0] mode, input logic [1:0] width,
                                  input int de, input int dd, input logic [1:0] err,
                                  output int st, output int ne, output int n_enc,
                                  output int n_dec, output int done_cyc, output int dec_cyc);
        n_enc = 0; n_dec = 0; dec_cyc = -1; ne = 0;
        if (mode == 2'd3 || width == 2'd3) begin
            st = 1; done_cyc = 1;
        end else if (mode == 2'd1) begin
            n_dec = 1; dec_cyc = 1;
            if (dd < c_T) begin st = 0; ne = int'(err); done_cyc = 1 + dd + 1; end
            else          begin st = 2; done_cyc = 1 + c_T; end
        end else begin
            n_enc = 1;
            if (de >= c_T) begin
                st = 2; done_cyc = 1 + c_T;
            end else if (mode == 2'd0) begin
                st = 0; done_cyc = 1 + de + 1;
            end else begin
                n_dec = 1; dec_cyc = 1 + de + 1;
                if (dd < c_T) begin st = 0; ne = int'(err); done_cyc = dec_cyc + dd + 1; end
                else          begin st = 2; done_cyc = dec_cyc + c_T; end
            end
        end
    endfunction

    // Idle cycles with stray done pulses; results must hold and nothing may fire
    task automatic idle_cycles(input int n);
        logic [1:0] st0, ne0, wl0;
        logic       src0;
        st0 = bus.status; ne0 = bus.num_of_errors; wl0 = bus.width_lat; src0 = bus.dec_src;
        for (int i = 0; i < n; i++) begin
            tick();
            bus.start    = 1'b0;
            bus.enc_done = 1'($urandom_range(0, 1));
            bus.dec_done = 1'($urandom_range(0, 1));
            bus.dec_err  = 2'($urandom_range(0, 2));
            check("idle_busy", bus.busy, 0);
            check("idle_opdone", bus.operation_done, 0);
            check("idle_kicks", {bus.enc_start, bus.dec_start}, 0);
        end
        check("hold_status", bus.status, st0);
        check("hold_errors", bus.num_of_errors, ne0);
        check("hold_width", bus.width_lat, wl0);
        check("hold_src", bus.dec_src, src0);
        tick();
        bus.enc_done = 1'b0;
        bus.dec_done = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] mode, input logic [1:0] width, input int de,
                          input int dd, input logic [1:0] err, input bit noise);
        int st, ne, n_enc, n_dec, done_cyc, dec_cyc;
        int enc_seen, dec_seen, done_seen, done_at, enc_at, dec_at, enc_fire, dec_fire;
        model(mode, width, de, dd, err, st, ne, n_enc, n_dec, done_cyc, dec_cyc);
        enc_seen = 0; dec_seen = 0; done_seen = 0; done_at = -1; enc_at = -1; dec_at = -1;
        enc_fire = -1; dec_fire = -1;
        tick();
        bus.start     = 1'b1;
        bus.ctrl_mode = mode;
        bus.cw_width  = width;
        bus.enc_done  = 1'b0;
        bus.dec_done  = 1'b0;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            tick();
            bus.start    = 1'b0;
            bus.enc_done = 1'b0;
            bus.dec_done = 1'b0;
            bus.dec_err  = 2'($urandom_range(0, 3));
            if (bus.enc_start) begin
                enc_seen++;
                if (enc_at < 0) enc_at = c;
                if (de < c_T) enc_fire = c + de;
            end
            if (bus.dec_start) begin
                dec_seen++;
                if (dec_at < 0) dec_at = c;
                if (dd < c_T) dec_fire = c + dd;
            end
            if (bus.operation_done) begin
                done_seen++;
                if (done_at < 0) done_at = c;
            end
            check($sformatf("busy_c%0d", c), bus.busy, (c <= done_cyc));
            if (c == enc_fire) bus.enc_done = 1'b1;
            if (c == dec_fire) begin
                bus.dec_done = 1'b1;
                bus.dec_err  = err;
            end
            if (noise) begin
                if (c <= done_cyc && $urandom_range(0, 3) == 0) begin
                    bus.start     = 1'b1;
                    bus.ctrl_mode = 2'($urandom_range(0, 3));
                    bus.cw_width  = 2'($urandom_range(0, 3));
                end
                if (mode == 2'd0 && $urandom_range(0, 2) == 0) bus.dec_done = 1'b1;
                if ((mode == 2'd1 || dec_at >= 0) && c != enc_fire && $urandom_range(0, 2) == 0)
                    bus.enc_done = 1'b1;
            end
        end
        check("enc_pulses", enc_seen, n_enc);
        check("dec_pulses", dec_seen, n_dec);
        check("done_pulses", done_seen, 1);
        check("done_cycle", done_at, done_cyc);
        if (n_enc > 0) check("enc_cycle", enc_at, 1);
        if (n_dec > 0) check("dec_cycle", dec_at, dec_cyc);
        check("status", bus.status, st);
        check("num_errors", bus.num_of_errors, ne);
        check("width_lat", bus.width_lat, width);
        if (st != 1 && (mode == 2'd1 || mode == 2'd2)) check("dec_src", bus.dec_src, (mode == 2'd2));
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.ctrl_mode = 2'b00;
        bus.cw_width  = 2'b00;
        bus.enc_done  = 1'b0;
        bus.dec_done  = 1'b0;
        bus.dec_err   = 2'b00;
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_outs", {bus.enc_start, bus.dec_start, bus.dec_src, bus.operation_done}, 0);
        check("rst_regs", {bus.width_lat, bus.num_of_errors, bus.status}, 0);
        rst = 1'b0;
        idle_cycles(3);

        // Directed: encode, full channel, illegal configs, timeout boundary
        run_op(2'd0, 2'd1, 3, 0, 2'd0, 1'b0);
        run_op(2'd2, 2'd2, 2, 4, 2'd1, 1'b0);
        run_op(2'd3, 2'd0, 0, 0, 2'd0, 1'b0);
        run_op(2'd1, 2'd3, 0, 0, 2'd0, 1'b0);
        run_op(2'd1, 2'd0, 0, c_T, 2'd2, 1'b0);
        run_op(2'd1, 2'd0, 0, c_T - 1, 2'd2, 1'b0);
        run_op(2'd0, 2'd2, 0, 0, 2'd0, 1'b1);
        run_op(2'd2, 2'd1, c_T - 1, 0, 2'd2, 1'b1);
        run_op(2'd2, 2'd1, c_T, 0, 2'd2, 1'b1);
        idle_cycles(4);

        // Reset in the middle of a decode stage
        tick();
        bus.start = 1'b1; bus.ctrl_mode = 2'd1; bus.cw_width = 2'd2;
        tick();
        bus.start = 1'b0;
        tick();
        check("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_outs", {bus.enc_start, bus.dec_start, bus.dec_src, bus.operation_done}, 0);
        check("midrst_regs", {bus.width_lat, bus.num_of_errors, bus.status}, 0);
        begin
            int late_done = 0;
            for (int i = 0; i < c_T + 4; i++) begin
                tick();
                if (bus.operation_done) late_done++;
            end
            check("midrst_no_done", late_done, 0);
        end
        run_op(2'd1, 2'd1, 0, 2, 2'd1, 1'b0);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            logic [1:0] m, w, e;
            m = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            w = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            e = 2'($urandom_range(0, 2));
            run_op(m, w, int'($urandom_range(0, c_T + 1)), int'($urandom_range(0, c_T + 1)), e, 1'b1);
            if ($urandom_range(0, 3) == 0) idle_cycles(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
